// File: rtl/gbuff_stream_reader_pkg.sv
// gbuff_stream_reader_pkg: shared global buffer sizes and reader FSM states
package gbuff_stream_reader_pkg;
  localparam int WORD_SIZE = 32;
  localparam int GBUFF_INDX_SIZE = 8;
  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN, RD_FIN} rd_state_e;
endpackage

// File: rtl/gbuff_stream_reader_if.sv
// gbuff_stream_reader_if: global buffer read port plus downstream valid/ready stream
interface gbuff_stream_reader_if
  import gbuff_stream_reader_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE,
  parameter int INDX_W = GBUFF_INDX_SIZE
);
  logic              gb_wr_en;
  logic [INDX_W-1:0] gb_index;
  logic [WORD_W-1:0] gb_rdata;
  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  modport master (output gb_wr_en, gb_index, m_valid, m_data, input gb_rdata, m_ready);
  modport slave  (input gb_wr_en, gb_index, m_valid, m_data, output gb_rdata, m_ready);
endinterface

// File: rtl/gbuff_skid_fifo.sv
// gbuff_skid_fifo: 2-entry FIFO with registered head, push+pop allowed at any occupancy
module gbuff_skid_fifo #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);
  logic [WORD_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  always_comb begin
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    head_d = (pop && cnt_q == 2'd2) ? tail_q : ((push && (pop || cnt_q == 2'd0)) ? din : head_q);
    tail_d = (push && (cnt_q == 2'd2 ? pop : (cnt_q == 2'd1 && !pop))) ? din : tail_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
  assign dout  = head_q;
  assign full  = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
  assign count = cnt_q;
endmodule

// File: rtl/gbuff_stream_reader.sv
// gbuff_stream_reader: walks an index range of the global buffer and streams the words out
module gbuff_stream_reader
  import gbuff_stream_reader_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE,
  parameter int INDX_W = GBUFF_INDX_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [INDX_W-1:0]    base_idx,
  input  logic [INDX_W:0]      length,
  output logic                 busy,
  output logic                 done,
  gbuff_stream_reader_if.master bus
);
  rd_state_e         state_q, state_d;
  logic [INDX_W-1:0] base_q, base_d, idx_q, idx_d;
  logic [INDX_W:0]   len_q, len_d, issued_q, issued_d, popped_q, popped_d;
  logic              inflight_q, inflight_d;
  logic              pop, push, issue, fifo_full, fifo_empty;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  always_comb begin
    pop        = bus.m_valid & bus.m_ready;
    push       = inflight_q && !(fifo_full && !pop);
    // occupancy the FIFO will see once the in-flight word lands
    occ        = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    issue      = state_q == RD_RUN && occ < 3'd2;
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q + (INDX_W+1)'(issue);
    popped_d   = popped_q + (INDX_W+1)'(pop);
    inflight_d = issue;
    idx_d      = issue ? base_q + issued_q[INDX_W-1:0] : idx_q;
    case (state_q)
      RD_IDLE: if (start) begin
        base_d   = base_idx;
        len_d    = length;
        issued_d = '0;
        popped_d = '0;
        state_d  = (length == '0) ? RD_FIN : RD_RUN;
      end
      RD_RUN:   state_d = (issued_d == len_q) ? RD_DRAIN : RD_RUN;
      RD_DRAIN: state_d = (popped_d == len_q) ? RD_FIN : RD_DRAIN;
      default:  state_d = RD_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
      idx_q      <= idx_d;
    end
  end
  gbuff_skid_fifo #(.WORD_W(WORD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.gb_rdata),
    .dout  (bus.m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );
  assign bus.m_valid  = !fifo_empty;
  assign bus.gb_wr_en = 1'b0;
  assign bus.gb_index = idx_d;
  assign busy         = state_q == RD_RUN || state_q == RD_DRAIN;
  assign done         = state_q == RD_FIN;
endmodule
